alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the register-file / ALU / writeback-mux datapath.
//  Accepts one command at a time over a valid/ready handshake and drives the datapath:
//  register read addresses, ALU Op and ShiftCount, mux select, write address and write enable.
//  Sits between the command source (bench, later the decode stage) and the existing datapath.
// PARAMETERS
//  ADDR_W   5   register address width
//  DATA_W   32  data / immediate width
//  OP_W     4   ALU op code width
//  SHAMT_W  5   shift count width
// PORTS
//  Clk          in   1        clock, rising edge
//  Rst_n        in   1        reset; synchronous, active-low
//  Cmd_valid    in   1        command present
//  Cmd_ready    out  1        sequencer idle, can accept
//  Cmd_op       in   OP_W     ALU op for this command
//  Cmd_rs       in   ADDR_W   source register A
//  Cmd_rt       in   ADDR_W   source register B
//  Cmd_rd       in   ADDR_W   destination register
//  Cmd_shamt    in   SHAMT_W  shift count
//  Cmd_use_imm  in   1        1: write Cmd_imm to rd; no ALU operation
//  Cmd_imm      in   DATA_W   immediate data
//  RR1, RR2     out  ADDR_W   register file read addresses
//  WR           out  ADDR_W   register file write address
//  WE           out  1        register file write enable
//  WD           out  DATA_W   immediate to the mux, input 0
//  Mux_Ctrl     out  1        0 = WD/immediate, 1 = ALU result
//  Op           out  OP_W     ALU op
//  ShiftCount   out  SHAMT_W  ALU shift count
//  ALU_result   in   DATA_W   ALU output, used only with SEQ_ZERO_FLAG_EN
//  Done         out  1        1-cycle pulse: command retired
//  Err          out  1        1-cycle pulse: illegal op, command dropped
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (Rst_n=0 at an edge): state IDLE.
//    - Every output is 0, including WE and Cmd_ready.
//    - Cmd_ready rises on the first edge with Rst_n=1.
//    - Reset mid-command abandons the command with no write. WE is 0 from the reset edge onward.
//  - States: IDLE -> READ -> EXEC -> WB -> IDLE for ALU commands; IDLE -> WB -> IDLE for immediate commands.
//  - IDLE:
//    - Cmd_ready=1.
//    - Accept on the edge where Cmd_valid & Cmd_ready; latch all Cmd_* fields. Cmd_* are ignored otherwise.
//    - Cmd_ready drops on the accept edge.
//  - Illegal op: legal ops are 0000 0001 0010 0110 0111 1000 1100 1101 1110 1111.
//    - Any other op with Cmd_use_imm=0 goes from IDLE to IDLE and pulses Err for 1 cycle.
//    - No write, no Done.
//  - READ: RR1=rs, RR2=rt, Op=op, ShiftCount=shamt. Held stable through EXEC and WB.
//  - EXEC: one settle cycle for the combinational ALU; WE=0.
//  - WB:
//    - WR=rd and WE=1 for exactly 1 cycle; Done=1 in the same cycle.
//    - Mux_Ctrl=1 for ALU commands; Mux_Ctrl=0 with WD=imm for immediate commands.
//  - Latency, where N is the accept edge:
//    - ALU command: WE high in cycle N+3.
//    - Immediate command: WE high in cycle N+1.
//    - Cmd_ready is high again in the cycle after WB.
//  - Outside WB, WE=0 always. Mux_Ctrl, WR and WD hold their last values, except that they are 0 after reset.
//  - Register 0 is an ordinary writable register; no special case for rd=0.
//  - rd equal to rs or rt is legal. The operands are read before WB, so the old value is used.
// CONFIGURATION
//  - SEQ_ZERO_FLAG_EN defined:
//    - Adds output Zero (1 bit), reset 0.
//    - On the WB edge of an ALU command, Zero <= (ALU_result == 0).
//    - On an immediate write, Zero <= (imm == 0).
//    - Otherwise Zero holds.
//  - SEQ_ZERO_FLAG_EN undefined: no Zero port; ALU_result is unused.
// STRUCTURE
//  - Shared package alu_seq_pkg holds:
//    - ALU op code localparams (ADD=0010, SUB=0110, AND=0000, OR=0001, NOR=1100, SLL=1110, SRL=1101, SRA=1111, SGT=1000, SLT=0111).
//    - State encoding (IDLE, READ, EXEC, WB).
//  - One sub-module, alu_op_decode: combinational Op -> legal flag.
//  - The FSM and the output registers stay in alu_op_sequencer.
// TESTING
//  - Reset: hold Rst_n=0 for 3 edges with Cmd_valid=1.
//    -> Cmd_ready=0, WE=0 and all outputs 0; no accept.
//    -> Cmd_ready=1 one edge after release.
//  - Immediate: use_imm=1, imm=-2, rd=0.
//    -> WE=1, WR=0, Mux_Ctrl=0, WD=-2 in cycle N+1; Done pulse; read r0 = -2.
//  - ADD: preload r0=-2, r31=1300; op=0010, rs=0, rt=31, rd=5.
//    -> WE at N+3, Mux_Ctrl=1, r5 = 1298; Cmd_ready low during N..N+3.
//  - SRA: r0=-2000, op=1111, shamt=2, rd=6 -> r6 = -500.
//    SLL with the same inputs and op=1110 -> r6 = -8000.
//  - Illegal op=0011 -> Err pulse 1 cycle later; WE never asserted; Cmd_ready high again.
//  - Reset mid-command: drop Rst_n in the EXEC cycle of an ADD to rd=7.
//    -> WE never asserted; r7 unchanged.
//  - Back-to-back: hold Cmd_valid high with 2 commands.
//    -> Second command accepted only on an IDLE edge; exactly one WE pulse per command.
//  - With SEQ_ZERO_FLAG_EN: SUB r5-r5 -> Zero=1.
//    -> A following immediate write of 7 -> Zero=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_seq_pkg : ALU op codes and sequencer state encoding                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SGT = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1101;
  localparam logic [3:0] ALU_SLL = 4'b1110;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// +--------------------------------------------------------------------------+
// | alu_op_decode : flags whether an ALU op code is one the datapath supports|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op_i,
  output logic            legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (op_i)
      OP_W'(ALU_AND), OP_W'(ALU_OR),  OP_W'(ALU_ADD), OP_W'(ALU_SUB),
      OP_W'(ALU_SLT), OP_W'(ALU_SGT), OP_W'(ALU_NOR), OP_W'(ALU_SRL),
      OP_W'(ALU_SLL), OP_W'(ALU_SRA): legal_o = 1'b1;
      default:                         legal_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// +--------------------------------------------------------------------------+
// | alu_op_sequencer : command-driven controller for regfile/ALU/WB-mux path |
// | Optional Zero flag output with `define SEQ_ZERO_FLAG_EN. Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Cmd_valid,
  output logic               Cmd_ready,
  input  logic [OP_W-1:0]    Cmd_op,
  input  logic [ADDR_W-1:0]  Cmd_rs,
  input  logic [ADDR_W-1:0]  Cmd_rt,
  input  logic [ADDR_W-1:0]  Cmd_rd,
  input  logic [SHAMT_W-1:0] Cmd_shamt,
  input  logic               Cmd_use_imm,
  input  logic [DATA_W-1:0]  Cmd_imm,
  output logic [ADDR_W-1:0]  RR1,
  output logic [ADDR_W-1:0]  RR2,
  output logic [ADDR_W-1:0]  WR,
  output logic               WE,
  output logic [DATA_W-1:0]  WD,
  output logic               Mux_Ctrl,
  output logic [OP_W-1:0]    Op,
  output logic [SHAMT_W-1:0] ShiftCount,
  input  logic [DATA_W-1:0]  ALU_result,
  output logic               Done,
  output logic               Err
`ifdef SEQ_ZERO_FLAG_EN
  ,
  output logic               Zero
`endif
);

  seq_state_e         state_q;
  logic               ready_q;
  logic [ADDR_W-1:0]  rr1_q;
  logic [ADDR_W-1:0]  rr2_q;
  logic [ADDR_W-1:0]  wr_q;
  logic [ADDR_W-1:0]  rd_q;
  logic               we_q;
  logic [DATA_W-1:0]  wd_q;
  logic               mux_q;
  logic [OP_W-1:0]    op_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               done_q;
  logic               err_q;
  logic               op_legal;

  alu_op_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .op_i    (Cmd_op),
    .legal_o (op_legal)
  );

`ifdef SEQ_ZERO_FLAG_EN
  logic zero_q;
  assign Zero = zero_q;
`else
  logic unused_alu_result;
  assign unused_alu_result = ^ALU_result;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rr1_q   <= '0;
      rr2_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      mux_q   <= 1'b0;
      op_q    <= '0;
      shamt_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Ready is low for the single cycle after reset release or an Err drop.
          ready_q <= 1'b1;
          if (Cmd_valid && ready_q) begin
            ready_q <= 1'b0;
            if (Cmd_use_imm) begin
              wr_q    <= Cmd_rd;
              wd_q    <= Cmd_imm;
              mux_q   <= 1'b0;
              we_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_WB;
            end else if (op_legal) begin
              rr1_q   <= Cmd_rs;
              rr2_q   <= Cmd_rt;
              op_q    <= Cmd_op;
              shamt_q <= Cmd_shamt;
              rd_q    <= Cmd_rd;
              state_q <= ST_READ;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        ST_READ: state_q <= ST_EXEC;
        ST_EXEC: begin
          wr_q    <= rd_q;
          mux_q   <= 1'b1;
          we_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_WB;
        end
        ST_WB: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
`ifdef SEQ_ZERO_FLAG_EN
          // Sampled on the same edge the register file captures the write.
          zero_q  <= mux_q ? (ALU_result == '0) : (wd_q == '0);
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Cmd_ready  = ready_q;
  assign RR1        = rr1_q;
  assign RR2        = rr2_q;
  assign WR         = wr_q;
  assign WE         = we_q;
  assign WD         = wd_q;
  assign Mux_Ctrl   = mux_q;
  assign Op         = op_q;
  assign ShiftCount = shamt_q;
  assign Done       = done_q;
  assign Err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_alu_op_sequencer : bench with regfile/ALU model around the sequencer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_op_sequencer;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic        use_imm;
    logic [31:0] imm;
  } cmd_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Cmd_valid;
  logic        Cmd_ready;
  logic [3:0]  Cmd_op;
  logic [4:0]  Cmd_rs, Cmd_rt, Cmd_rd, Cmd_shamt;
  logic        Cmd_use_imm;
  logic [31:0] Cmd_imm;
  logic [4:0]  RR1, RR2, WR;
  logic        WE;
  logic [31:0] WD;
  logic        Mux_Ctrl;
  logic [3:0]  Op;
  logic [4:0]  ShiftCount;
  logic [31:0] ALU_result;
  logic        Done;
  logic        Err;
`ifdef SEQ_ZERO_FLAG_EN
  logic        Zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_writes = 0;
  int we_seen = 0;
  logic exp_zero = 1'b0;
  logic rf_clr;
  logic [31:0] rf     [32];
  logic [31:0] ref_rf [32];

  always #5 Clk = ~Clk;

  alu_op_sequencer dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Cmd_valid   (Cmd_valid),
    .Cmd_ready   (Cmd_ready),
    .Cmd_op      (Cmd_op),
    .Cmd_rs      (Cmd_rs),
    .Cmd_rt      (Cmd_rt),
    .Cmd_rd      (Cmd_rd),
    .Cmd_shamt   (Cmd_shamt),
    .Cmd_use_imm (Cmd_use_imm),
    .Cmd_imm     (Cmd_imm),
    .RR1         (RR1),
    .RR2         (RR2),
    .WR          (WR),
    .WE          (WE),
    .WD          (WD),
    .Mux_Ctrl    (Mux_Ctrl),
    .Op          (Op),
    .ShiftCount  (ShiftCount),
    .ALU_result  (ALU_result),
    .Done        (Done),
    .Err         (Err)
`ifdef SEQ_ZERO_FLAG_EN
    ,
    .Zero        (Zero)
`endif
  );

  // ALU behaviour defined directly from the op-code table.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return ~(a | b);
      4'b1110: return a << sh;
      4'b1101: return a >> sh;
      4'b1111: return 32'($signed(a) >>> sh);
      4'b1000: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit op_ok(input logic [3:0] op);
    int v;
    v = int'(op);
    return v inside {0, 1, 2, 6, 7, 8, 12, 13, 14, 15};
  endfunction

  // Datapath around the DUT: register file and combinational ALU.
  always_comb ALU_result = alu_f(Op, rf[RR1], rf[RR2], ShiftCount);

  always @(posedge Clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (WE) begin
      rf[WR] <= Mux_Ctrl ? ALU_result : WD;
    end
  end

  always @(negedge Clk) if (WE === 1'b1) we_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic ui,
                              input logic [31:0] imm);
    cmd_t c;
    c.op = op; c.rs = rs; c.rt = rt; c.rd = rd; c.sh = sh; c.use_imm = ui; c.imm = imm;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), ($urandom_range(0, 3) == 0), $urandom);
  endfunction

  task automatic drive(input cmd_t c);
    Cmd_op = c.op; Cmd_rs = c.rs; Cmd_rt = c.rt; Cmd_rd = c.rd;
    Cmd_shamt = c.sh; Cmd_use_imm = c.use_imm; Cmd_imm = c.imm;
    Cmd_valid = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({Cmd_ready, RR1, RR2, WR, WE, Mux_Ctrl, Op, ShiftCount, Done, Err});
  endfunction

  // Issues one command and checks its cycle-by-cycle behaviour and the write result.
  task automatic run_cmd(input cmd_t c, input bit hold, input cmd_t nxt);
    int w;
    bit legal;
    logic [31:0] res;
    w = 0;
    res = 32'd0;
    @(negedge Clk);
    drive(c);
    while (Cmd_ready !== 1'b1 && w < 20) begin
      @(negedge Clk);
      w++;
    end
    check("accept_wait", 32'(w < 20), 1);
    if (w >= 20) begin
      Cmd_valid = 1'b0;
      return;
    end
    @(posedge Clk); #1;
    if (hold) drive(nxt);
    else Cmd_valid = 1'b0;
    legal = c.use_imm || op_ok(c.op);
    check("ready_drop", 32'(Cmd_ready), 0);
    if (!legal) begin
      check("err_pulse", 32'({Err, WE, Done}), 'b100);
      @(posedge Clk); #1;
      check("err_clear", 32'({Err, WE, Done, Cmd_ready}), 'b0001);
    end else if (c.use_imm) begin
      res = c.imm;
      check("imm_wb_ctl", 32'({WE, Mux_Ctrl, Done, Err}), 'b1010);
      check("imm_wr", 32'(WR), 32'(c.rd));
      check("imm_wd", WD, c.imm);
      @(posedge Clk); #1;
      check("imm_after", 32'({WE, Done, Cmd_ready}), 'b001);
    end else begin
      res = alu_f(c.op, ref_rf[c.rs], ref_rf[c.rt], c.sh);
      check("read_addr", 32'({RR1, RR2}), 32'({c.rs, c.rt}));
      check("read_op", 32'({Op, ShiftCount}), 32'({c.op, c.sh}));
      check("read_we", 32'({WE, Done, Err}), 0);
      @(posedge Clk); #1;
      check("exec_we", 32'({WE, Done, Cmd_ready}), 0);
      @(posedge Clk); #1;
      check("wb_ctl", 32'({WE, Mux_Ctrl, Done, Cmd_ready}), 'b1110);
      check("wb_wr", 32'(WR), 32'(c.rd));
      check("wb_hold", 32'({RR1, RR2, Op, ShiftCount}), 32'({c.rs, c.rt, c.op, c.sh}));
      @(posedge Clk); #1;
      check("alu_after", 32'({WE, Done, Cmd_ready}), 'b001);
    end
    if (legal) begin
      ref_rf[c.rd] = res;
      exp_writes++;
      exp_zero = (res == 32'd0);
    end
    check("rf_data", rf[c.rd], ref_rf[c.rd]);
`ifdef SEQ_ZERO_FLAG_EN
    check("zero_flag", 32'(Zero), 32'(exp_zero));
`endif
  endtask

  initial begin
    cmd_t c, n, dummy;
    bit hold;
    dummy = mk(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;

    // Reset held for 3 edges with a valid immediate command presented.
    rf_clr = 1'b1;
    Rst_n  = 1'b0;
    drive(mk(4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 1'b1, 32'd5));
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check("rst_outs", all_outs(), 0);
      check("rst_wd", WD, 0);
`ifdef SEQ_ZERO_FLAG_EN
      check("rst_zero", 32'(Zero), 0);
`endif
    end
    rf_clr    = 1'b0;
    Rst_n     = 1'b1;
    Cmd_valid = 1'b0;
    @(posedge Clk); #1;
    check("rst_release_ready", 32'({Cmd_ready, WE}), 'b10);

    // Immediate -2 into r0, then r31 = 1300 and ADD r5 = r0 + r31.
    run_cmd(mk(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -32'sd2), 1'b0, dummy);
    check("r0_imm", rf[0], 32'hFFFF_FFFE);
    run_cmd(mk(4'd0, 5'd0, 5'd0, 5'd31, 5'd0, 1'b1, 32'd1300), 1'b0, dummy);
    run_cmd(mk(4'b0010, 5'd0, 5'd31, 5'd5, 5'd0, 1'b0, 32'd0), 1'b0, dummy);
    check("add_r5", rf[5], 32'd1298);

    // Shifts of -2000.
    run_cmd(mk(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, -32'sd2000), 1'b0, dummy);
    run_cmd(mk(4'b1111, 5'd0, 5'd0, 5'd6, 5'd2, 1'b0, 32'd0), 1'b0, dummy);
    check("sra_r6", rf[6], -32'sd500);
    run_cmd(mk(4'b1110, 5'd0, 5'd0, 5'd6, 5'd2, 1'b0, 32'd0), 1'b0, dummy);
    check("sll_r6", rf[6], -32'sd8000);

    // Illegal op.
    run_cmd(mk(4'b0011, 5'd1, 5'd2, 5'd9, 5'd0, 1'b0, 32'd0), 1'b0, dummy);

    // Reset during EXEC of an ADD to r7.
    @(negedge Clk);
    drive(mk(4'b0010, 5'd0, 5'd31, 5'd7, 5'd0, 1'b0, 32'd0));
    check("mid_ready", 32'(Cmd_ready), 1);
    @(posedge Clk); #1;
    Cmd_valid = 1'b0;
    @(posedge Clk); #1;
    check("mid_exec", 32'({WE, Done, Cmd_ready}), 0);
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    check("mid_rst_outs", all_outs(), 0);
    Rst_n = 1'b1;
    exp_zero = 1'b0;
    @(posedge Clk); #1;
    check("mid_rst_ready", 32'({Cmd_ready, WE}), 'b10);
    check("mid_rst_r7", rf[7], ref_rf[7]);
    check("mid_rst_writes", we_seen, exp_writes);

    // Back-to-back with Cmd_valid held, second depends on first.
    c = mk(4'b0010, 5'd5, 5'd31, 5'd8, 5'd0, 1'b0, 32'd0);
    n = mk(4'b0110, 5'd8, 5'd0, 5'd9, 5'd0, 1'b0, 32'd0);
    run_cmd(c, 1'b1, n);
    run_cmd(n, 1'b0, dummy);
    check("b2b_writes", we_seen, exp_writes);

    // Zero flag from SUB r5-r5, then cleared by an immediate 7.
    run_cmd(mk(4'b0110, 5'd5, 5'd5, 5'd10, 5'd0, 1'b0, 32'd0), 1'b0, dummy);
    check("sub_zero_r10", rf[10], 0);
`ifdef SEQ_ZERO_FLAG_EN
    check("zero_set", 32'(Zero), 1);
`endif
    run_cmd(mk(4'd0, 5'd0, 5'd0, 5'd11, 5'd0, 1'b1, 32'd7), 1'b0, dummy);
`ifdef SEQ_ZERO_FLAG_EN
    check("zero_clear", 32'(Zero), 0);
`endif

    // Randomized commands, some back-to-back, some illegal.
    c = rnd_cmd();
    for (int i = 0; i < 60; i++) begin
      n = rnd_cmd();
      hold = ($urandom_range(0, 1) == 1);
      run_cmd(c, hold, n);
      c = n;
    end
    Cmd_valid = 1'b0;
    @(posedge Clk); #1;
    check("total_writes", we_seen, exp_writes);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
